// File: rtl/core_sequencer.sv
`timescale 1ns/1ps
// core_sequencer: multi-cycle FETCH/DECODE/EXECUTE/MEM/WB control FSM for a
// small RV32I-style core. All control outputs are Moore outputs held in
// registers that are loaded together with the next state.
// Optional feature macro: CORE_SEQ_TRAP_EN -- when defined, an illegal opcode
// traps into HALT (left only by reset) and the illegal port is present; when
// undefined, illegal opcodes retire as NOPs.
module core_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  input  logic        branch_taken,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic [31:0] instr,
  output logic [31:0] load_data,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic [2:0]  state,
  output logic [31:0] retire_count
`ifdef CORE_SEQ_TRAP_EN
  ,
  output logic        illegal
`endif
);

  localparam logic [6:0] OP_ALUREG = 7'b0110011;
  localparam logic [6:0] OP_ALUIMM = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    EXECUTE = 3'd2,
    MEM     = 3'd3,
    WB      = 3'd4
`ifdef CORE_SEQ_TRAP_EN
    ,
    HALT    = 3'd5
`endif
  } state_t;

  state_t     st;
  logic [6:0] opcode;
  logic       op_mem;
  logic       op_store;
  logic       wb_rf_we;
  logic [1:0] wb_wb_sel;
  logic [1:0] wb_pc_sel;
`ifdef CORE_SEQ_TRAP_EN
  logic       op_legal;
`endif

  assign opcode = instr[6:0];
  assign state  = st;

  // Classify the latched instruction and precompute its writeback controls.
  always_comb begin
    op_mem    = 1'b0;
    op_store  = 1'b0;
    wb_rf_we  = 1'b0;
    wb_wb_sel = 2'b00;
    wb_pc_sel = 2'b00;
`ifdef CORE_SEQ_TRAP_EN
    op_legal  = 1'b1;
`endif
    case (opcode)
      OP_ALUREG, OP_ALUIMM, OP_AUIPC: wb_rf_we = 1'b1;
      OP_LUI: begin
        wb_rf_we  = 1'b1;
        wb_wb_sel = 2'b11;
      end
      OP_LOAD: begin
        wb_rf_we  = 1'b1;
        wb_wb_sel = 2'b01;
        op_mem    = 1'b1;
      end
      OP_STORE: begin
        op_mem   = 1'b1;
        op_store = 1'b1;
      end
      OP_BRANCH: wb_pc_sel = branch_taken ? 2'b01 : 2'b00;
      OP_JAL: begin
        wb_rf_we  = 1'b1;
        wb_wb_sel = 2'b10;
        wb_pc_sel = 2'b01;
      end
      OP_JALR: begin
        wb_rf_we  = 1'b1;
        wb_wb_sel = 2'b10;
        wb_pc_sel = 2'b10;
      end
      default: begin
`ifdef CORE_SEQ_TRAP_EN
        op_legal = 1'b0;
`endif
      end
    endcase
    // Writes to x0 are discarded.
    if (instr[11:7] == 5'd0) wb_rf_we = 1'b0;
  end

  // State register plus registered Moore outputs for the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      st           <= FETCH;
      instr        <= '0;
      load_data    <= '0;
      retire_count <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      addr_sel     <= 1'b0;
      rf_we        <= 1'b0;
      wb_sel       <= 2'b00;
      pc_we        <= 1'b0;
      pc_sel       <= 2'b00;
`ifdef CORE_SEQ_TRAP_EN
      illegal      <= 1'b0;
`endif
    end else begin
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      addr_sel <= 1'b0;
      rf_we    <= 1'b0;
      wb_sel   <= 2'b00;
      pc_we    <= 1'b0;
      pc_sel   <= 2'b00;
      case (st)
        FETCH: begin
          // The first FETCH cycle after reset has mem_req low, so an early
          // mem_ready is ignored and the request is raised next cycle.
          if (mem_req && mem_ready) begin
            instr <= mem_rdata;
            st    <= DECODE;
          end else begin
            mem_req <= 1'b1;
          end
        end
        DECODE: begin
`ifdef CORE_SEQ_TRAP_EN
          if (!op_legal) begin
            st      <= HALT;
            illegal <= 1'b1;
          end else begin
            st <= EXECUTE;
          end
`else
          st <= EXECUTE;
`endif
        end
        EXECUTE: begin
          if (op_mem) begin
            st       <= MEM;
            mem_req  <= 1'b1;
            addr_sel <= 1'b1;
            mem_we   <= op_store;
          end else begin
            st     <= WB;
            pc_we  <= 1'b1;
            rf_we  <= wb_rf_we;
            wb_sel <= wb_wb_sel;
            pc_sel <= wb_pc_sel;
          end
        end
        MEM: begin
          if (mem_ready) begin
            if (!op_store) load_data <= mem_rdata;
            st     <= WB;
            pc_we  <= 1'b1;
            rf_we  <= wb_rf_we;
            wb_sel <= wb_wb_sel;
            pc_sel <= wb_pc_sel;
          end else begin
            mem_req  <= 1'b1;
            addr_sel <= 1'b1;
            mem_we   <= op_store;
          end
        end
        WB: begin
          retire_count <= retire_count + 32'd1;
          st           <= FETCH;
          mem_req      <= 1'b1;
        end
`ifdef CORE_SEQ_TRAP_EN
        HALT: st <= HALT;
`endif
        default: st <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_core_sequencer.sv
`timescale 1ns/1ps
// tb_core_sequencer: directed instruction sequences; a transaction-level model
// expands each instruction into its expected per-cycle output trace, and a
// negedge compare process checks the DUT against that trace every cycle.
module tb_core_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        branch_taken;
  logic        mem_req;
  logic        mem_we;
  logic        addr_sel;
  logic [31:0] instr;
  logic [31:0] load_data;
  logic        rf_we;
  logic [1:0]  wb_sel;
  logic        pc_we;
  logic [1:0]  pc_sel;
  logic [2:0]  state;
  logic [31:0] retire_count;
  logic        illegal_w;

  localparam logic [31:0] JUNK = 32'hBAD0_C0DE;

  core_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .branch_taken (branch_taken),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .addr_sel     (addr_sel),
    .instr        (instr),
    .load_data    (load_data),
    .rf_we        (rf_we),
    .wb_sel       (wb_sel),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .state        (state),
    .retire_count (retire_count)
`ifdef CORE_SEQ_TRAP_EN
    ,
    .illegal      (illegal_w)
`endif
  );

`ifndef CORE_SEQ_TRAP_EN
  assign illegal_w = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  st;
    logic        req;
    logic        we;
    logic        asel;
    logic        rfwe;
    logic        pcwe;
    logic [1:0]  wbs;
    logic [1:0]  pcs;
    logic [31:0] ins;
    logic [31:0] ld;
    logic [31:0] ret;
    logic        ill;
  } obs_t;

  obs_t        expq[$];
  string       tagq[$];
  obs_t        act_v;
  obs_t        exp_v;
  string       tag_v;
  int          n_cmp = 0;
  int          n_fail = 0;
  int          memhold = 0;

  // Architectural model state
  logic [31:0] m_instr;
  logic [31:0] m_load;
  logic [31:0] m_retire;
  logic        m_ill;

  // Cycle-by-cycle comparison against the expected trace
  always @(negedge clk) begin
    act_v.st   = state;
    act_v.req  = mem_req;
    act_v.we   = mem_we;
    act_v.asel = addr_sel;
    act_v.rfwe = rf_we;
    act_v.pcwe = pc_we;
    act_v.wbs  = wb_sel;
    act_v.pcs  = pc_sel;
    act_v.ins  = instr;
    act_v.ld   = load_data;
    act_v.ret  = retire_count;
    act_v.ill  = illegal_w;
    if (mem_req && addr_sel) memhold++;
    if (expq.size() > 0) begin
      exp_v = expq.pop_front();
      tag_v = tagq.pop_front();
      n_cmp++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL %s: got st=%0d req=%b we=%b asel=%b rfwe=%b pcwe=%b wbs=%0d pcs=%0d ins=%h ld=%h ret=%0d ill=%b, want st=%0d req=%b we=%b asel=%b rfwe=%b pcwe=%b wbs=%0d pcs=%0d ins=%h ld=%h ret=%0d ill=%b",
                 tag_v, act_v.st, act_v.req, act_v.we, act_v.asel, act_v.rfwe, act_v.pcwe, act_v.wbs, act_v.pcs,
                 act_v.ins, act_v.ld, act_v.ret, act_v.ill,
                 exp_v.st, exp_v.req, exp_v.we, exp_v.asel, exp_v.rfwe, exp_v.pcwe, exp_v.wbs, exp_v.pcs,
                 exp_v.ins, exp_v.ld, exp_v.ret, exp_v.ill);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  // Baseline observation for a given state: all controls idle, data from model.
  function automatic obs_t mk(input logic [2:0] s);
    obs_t e;
    e     = '0;
    e.st  = s;
    e.ins = m_instr;
    e.ld  = m_load;
    e.ret = m_retire;
    e.ill = m_ill;
    return e;
  endfunction

  function automatic bit is_legal(input logic [6:0] op);
    return op == 7'h33 || op == 7'h13 || op == 7'h63 || op == 7'h03 || op == 7'h23 ||
           op == 7'h37 || op == 7'h17 || op == 7'h6F || op == 7'h67;
  endfunction

  // Writeback controls from the instruction-class rules.
  task automatic wb_expect(input logic [31:0] w, input logic bt,
                           output logic rfwe, output logic [1:0] wbs, output logic [1:0] pcs);
    logic [6:0] op;
    op   = w[6:0];
    rfwe = (op == 7'h33 || op == 7'h13 || op == 7'h03 || op == 7'h37 ||
            op == 7'h17 || op == 7'h6F || op == 7'h67) && (w[11:7] != 5'd0);
    wbs  = (op == 7'h03) ? 2'd1 : (op == 7'h6F || op == 7'h67) ? 2'd2 : (op == 7'h37) ? 2'd3 : 2'd0;
    pcs  = (op == 7'h6F || (op == 7'h63 && bt)) ? 2'd1 : (op == 7'h67) ? 2'd2 : 2'd0;
  endtask

  // One clock cycle: drive inputs, queue the expected outputs, advance.
  task automatic cyc(input obs_t e, input logic rdy, input logic [31:0] rd, input string t);
    mem_ready = rdy;
    mem_rdata = rd;
    expq.push_back(e);
    tagq.push_back(t);
    @(posedge clk);
    #1;
  endtask

  // Called just after a clock edge that sampled reset=1.
  task automatic reset_tail();
    m_instr  = '0;
    m_load   = '0;
    m_retire = '0;
    m_ill    = 1'b0;
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    cyc(mk(3'd0), 1'b1, JUNK, "reset_hold");
    reset = 1'b0;
    cyc(mk(3'd0), 1'b1, JUNK, "reset_idle");
  endtask

  task automatic run_instr(input logic [31:0] w, input int fst, input int mst,
                           input logic bt, input logic [31:0] ldv, input bit abort);
    obs_t       e;
    logic       rfwe;
    logic [1:0] wbs;
    logic [1:0] pcs;
    bit         ld;
    bit         sto;
    ld  = (w[6:0] == 7'h03);
    sto = (w[6:0] == 7'h23);
    branch_taken = bt;
    e = mk(3'd0);
    e.req = 1'b1;
    for (int i = 0; i < fst; i++) cyc(e, 1'b0, JUNK + i, "fetch_wait");
    cyc(e, 1'b1, w, "fetch");
    m_instr = w;
    cyc(mk(3'd1), 1'b0, JUNK, "decode");
`ifdef CORE_SEQ_TRAP_EN
    if (!is_legal(w[6:0])) begin
      m_ill = 1'b1;
      chk("halt_state", {29'd0, state}, 32'd5);
      chk("halt_illegal", {31'd0, illegal_w}, 32'd1);
      chk("halt_mem_req", {31'd0, mem_req}, 32'd0);
      for (int i = 0; i < 3; i++) cyc(mk(3'd5), 1'b1, JUNK, "halt");
      reset = 1'b1;
      cyc(mk(3'd5), 1'b1, JUNK, "halt_reset");
      reset_tail();
      return;
    end
`endif
    cyc(mk(3'd2), 1'b0, JUNK, "execute");
    if (ld || sto) begin
      e = mk(3'd3);
      e.req  = 1'b1;
      e.asel = 1'b1;
      e.we   = sto;
      if (abort) begin
        reset = 1'b1;
        cyc(e, 1'b0, JUNK, "mem_abort");
        reset_tail();
        return;
      end
      for (int i = 0; i < mst; i++) cyc(e, 1'b0, JUNK, "mem_wait");
      cyc(e, 1'b1, ldv, "mem");
      if (ld) m_load = ldv;
    end
    wb_expect(w, bt, rfwe, wbs, pcs);
    e = mk(3'd4);
    e.pcwe = 1'b1;
    e.rfwe = rfwe;
    e.wbs  = wbs;
    e.pcs  = pcs;
    cyc(e, 1'b0, JUNK, "wb");
    m_retire = m_retire + 32'd1;
  endtask

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  // Directed stimulus
  initial begin
    reset        = 1'b1;
    mem_ready    = 1'b0;
    mem_rdata    = '0;
    branch_taken = 1'b0;
    m_instr      = '0;
    m_load       = '0;
    m_retire     = '0;
    m_ill        = 1'b0;
    @(posedge clk);
    #1;
    reset_tail();

    run_instr(32'h00500093, 0, 0, 1'b0, '0, 1'b0);            // addi x1,x0,5
    chk("retire_after_addi", retire_count, 32'd1);
    chk("pc_we_cleared", {31'd0, pc_we}, 32'd0);

    memhold = 0;
    run_instr(32'h0000A103, 0, 3, 1'b0, 32'hDEADBEEF, 1'b0);  // lw x2
    chk("lw_load_data", load_data, 32'hDEADBEEF);
    chk("lw_mem_req_held", memhold, 32'd4);

    run_instr(32'h00000463, 0, 0, 1'b1, '0, 1'b0);            // beq taken
    run_instr(32'h00000463, 0, 0, 1'b0, '0, 1'b0);            // beq not taken
    run_instr(32'h00500013, 1, 0, 1'b1, '0, 1'b0);            // addi x0
    chk("retire_after_x0", retire_count, 32'd5);
    run_instr(32'h002081B3, 2, 0, 1'b0, '0, 1'b0);            // add x3
    run_instr(32'h008000EF, 0, 0, 1'b0, '0, 1'b0);            // jal x1
    run_instr(32'h000080E7, 0, 0, 1'b1, '0, 1'b0);            // jalr x1
    run_instr(32'h123452B7, 0, 0, 1'b0, '0, 1'b0);            // lui x5
    run_instr(32'h00001317, 0, 0, 1'b0, '0, 1'b0);            // auipc x6
    run_instr(32'h0020A023, 0, 1, 1'b0, '0, 1'b0);            // sw
    chk("sw_keeps_load_data", load_data, 32'hDEADBEEF);

    run_instr(32'h0020A023, 0, 2, 1'b0, '0, 1'b1);            // sw aborted by reset in MEM

    run_instr(32'hFFFFFFFF, 0, 0, 1'b0, '0, 1'b0);            // illegal opcode
    run_instr(32'h00500093, 0, 0, 1'b0, '0, 1'b0);            // recovery
    chk("trace_drained", expq.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  reset, synchronous and active-high.
REQ-003 SHALL have port: mem_rdata  input  32  memory read data, sampled when mem_ready=1.
REQ-004 SHALL have port: mem_ready  input  1  memory acknowledge for the current mem_req; ignored when mem_req=0.
REQ-005 SHALL have port: branch_taken  input  1  comparator result for the current B-type instruction.
REQ-006 SHALL have port: mem_req  output  1  memory request, held until mem_ready.
REQ-007 SHALL have port: mem_we  output  1  1=store, 0=read.
REQ-008 SHALL have port: addr_sel  output  1  0=PC address (fetch), 1=ALU address (load/store).
REQ-009 SHALL have port: instr  output  32  latched instruction register.
REQ-010 SHALL have port: load_data  output  32  latched load data.
REQ-011 SHALL have port: rf_we  output  1  register-file write enable.
REQ-012 SHALL have port: wb_sel  output  2  00=ALU, 01=load_data, 10=PC+4, 11=U-immediate.
REQ-013 SHALL have port: pc_we  output  1  PC update enable.
REQ-014 SHALL have port: pc_sel  output  2  00=PC+4, 01=PC+B/J-immediate, 10=JALR target.
REQ-015 SHALL have port: state  output  3  current FSM state encoding.
REQ-016 SHALL have port: retire_count  output  32  retired-instruction counter.
REQ-017 SHALL have port: illegal  output  1  illegal-opcode flag (present only with CORE_SEQ_TRAP_EN).

Function
REQ-018 SHALL implement the FSM states FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, HALT=5, with all control outputs decoded from state (Moore).
REQ-019 SHALL, in FETCH, drive mem_req=1, mem_we=0, addr_sel=0; on mem_ready=1, load instr<=mem_rdata and go to DECODE; otherwise stay in FETCH.
REQ-020 SHALL classify opcodes instr[6:0] as: ALUreg 0110011, ALUimm 0010011, Branch 1100011, Load 0000011, Store 0100011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111; any other value is illegal.
REQ-021 SHALL spend exactly one cycle in DECODE, then go to EXECUTE (or to HALT per REQ-031).
REQ-022 SHALL spend exactly one cycle in EXECUTE, then go to MEM for Load/Store and to WB for all other opcodes.
REQ-023 SHALL, in MEM, drive mem_req=1, addr_sel=1, mem_we=1 for Store and 0 for Load; on mem_ready=1, latch load_data<=mem_rdata (Load only) and go to WB.
REQ-024 SHALL, in WB, assert pc_we=1 for one cycle and return to FETCH.
REQ-025 SHALL, in WB, set pc_sel=01 for JAL or (Branch and branch_taken=1), 10 for JALR, and 00 otherwise.
REQ-026 SHALL, in WB, set rf_we=1 for ALUreg, ALUimm, Load, LUI, AUIPC, JAL, JALR, except that rf_we=0 when instr[11:7]=0.
REQ-027 SHALL, in WB, set wb_sel=01 for Load, 10 for JAL/JALR, 11 for LUI, and 00 otherwise (AUIPC uses the ALU).
REQ-028 SHALL increment retire_count by 1 in every WB cycle, wrapping 0xFFFFFFFF to 0.
REQ-029 SHALL have a minimum latency, with mem_ready=1 throughout, of 4 cycles per non-memory instruction and 5 cycles per Load/Store; each cycle mem_ready stays low adds one cycle.
REQ-030 SHALL drive rf_we, pc_we, mem_req and mem_we to 0 in every state where they are not specified above.

Reset
REQ-031 SHALL, on reset=1 at a clock edge, from any state (including mid-request), set state=FETCH, instr=0, load_data=0, retire_count=0, illegal=0 and abandon any outstanding request.
REQ-032 SHALL drive all control outputs to 0 while reset=1, with FETCH's mem_req first asserted in the first cycle after reset deasserts.

Configuration
REQ-033 SHALL, when CORE_SEQ_TRAP_EN is defined, transition from DECODE to HALT on an illegal opcode and set illegal=1 with all control outputs 0; HALT is left only by reset.
REQ-034 SHALL, when CORE_SEQ_TRAP_EN is undefined, treat an illegal opcode as a NOP (DECODE->EXECUTE->WB, rf_we=0, pc_sel=00, retire counted), with the illegal port and HALT state absent.

Verification
REQ-035 SHALL cover: reset, mem_ready=1, fetch 0x00500093 (addi x1,x0,5) -> states 0,1,2,4; WB has rf_we=1, wb_sel=00, pc_sel=00, pc_we=1; retire_count=1.
REQ-036 SHALL cover: fetch 0x0000A103 (lw), mem_ready low 3 cycles in MEM, then rdata=0xDEADBEEF -> mem_req held 4 cycles with addr_sel=1 and mem_we=0; load_data=0xDEADBEEF; WB has wb_sel=01.
REQ-037 SHALL cover: fetch 0x00000463 (beq) with branch_taken=1 -> pc_sel=01, rf_we=0; repeat with branch_taken=0 -> pc_sel=00.
REQ-038 SHALL cover: fetch 0x00500013 (addi x0) -> WB has rf_we=0 and retire_count incremented.
REQ-039 SHALL cover: reset asserted during MEM of sw 0x0020A023 with mem_req=1 -> next cycle state=0, mem_req=0, instr=0.
REQ-040 SHALL cover: fetch 0xFFFFFFFF -> with CORE_SEQ_TRAP_EN, state=5, illegal=1 and mem_req=0 until reset; without it, NOP retire with pc_sel=00.
